// File: rtl/clock_divider.sv
// Integer clock divider: produces a registered square wave at I_CLK_FREQ/N, where N = I_CLK_FREQ/O_CLK_FREQ.
// N == 1 degenerates to a reset-gated pass-through of the input clock.
module clock_divider #(
  parameter int unsigned I_CLK_FREQ = 100_000_000,
  parameter int unsigned O_CLK_FREQ = 1_000_000
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
);

  // Guarded divisor keeps elaboration alive long enough to report a zero output frequency cleanly.
  localparam int unsigned N = I_CLK_FREQ / ((O_CLK_FREQ > 0) ? O_CLK_FREQ : 1);

  if (O_CLK_FREQ == 0) begin : g_bad_zero
    $fatal(1, "clock_divider: O_CLK_FREQ must be greater than zero");
  end

  if (O_CLK_FREQ > I_CLK_FREQ) begin : g_bad_ratio
    $fatal(1, "clock_divider: O_CLK_FREQ (%0d) exceeds I_CLK_FREQ (%0d)", O_CLK_FREQ, I_CLK_FREQ);
  end

  if (N <= 1) begin : g_pass
    assign clk_out = clk_in & ~reset;
  end else begin : g_div
    localparam int unsigned W = $clog2(N);
    localparam logic [W-1:0] LAST       = W'(N - 1);
    localparam logic [W-1:0] HIGH_START = W'((N + 1) / 2);

    // Power-up values for FPGA targets; reset still defines the state everywhere else.
    logic [W-1:0] cnt_q = '0;
    logic [W-1:0] cnt_d;
    logic         clk_out_q = 1'b0;
    logic         clk_out_d;

    // Out-of-range counts (>= N) fall into the wrap branch, so a corrupted count recovers in one edge.
    always_comb begin
      cnt_d     = (cnt_q >= LAST) ? '0 : cnt_q + 1'b1;
      clk_out_d = (cnt_d >= HIGH_START);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt_q     <= '0;
        clk_out_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        clk_out_q <= clk_out_d;
      end
    end

    assign clk_out = clk_out_q;
  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: several ratios share one clock and reset; outputs are compared against
// a position-in-period model, plus period, pass-through and mid-period-reset checks.
module tb_clock_divider;

  localparam int NUM = 6;
  localparam int NS [NUM] = '{4, 1, 3, 2, 10, 14};
  localparam int PASS_IDX = 1;
  localparam int N10_IDX  = 4;

  logic           clk_in = 1'b0;
  logic           reset  = 1'b1;
  logic [NUM-1:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int k         [NUM];
  int last_rise [NUM];
  logic prev    [NUM];

  always #5 clk_in = ~clk_in;

  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(25_000_000))
    u_n4  (.clk_in(clk_in), .reset(reset), .clk_out(outs[0]));
  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(100_000_000))
    u_n1  (.clk_in(clk_in), .reset(reset), .clk_out(outs[1]));
  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(33_000_000))
    u_n3  (.clk_in(clk_in), .reset(reset), .clk_out(outs[2]));
  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(50_000_000))
    u_n2  (.clk_in(clk_in), .reset(reset), .clk_out(outs[3]));
  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(10_000_000))
    u_n10 (.clk_in(clk_in), .reset(reset), .clk_out(outs[4]));
  clock_divider #(.I_CLK_FREQ(100_000_000), .O_CLK_FREQ(7_000_000))
    u_n14 (.clk_in(clk_in), .reset(reset), .clk_out(outs[5]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Edge k after reset sits at position k mod n in the period; the first ceil(n/2) positions are low.
  function automatic logic model_out(input int n, input int edges);
    return logic'((edges % n) >= (n + 1) / 2);
  endfunction

  // Called on a falling edge: drive reset, take one rising edge, then check both clock phases.
  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk_in);
    cyc++;
    for (int i = 0; i < NUM; i++) k[i] = rst ? 0 : k[i] + 1;
    #1;
    check("pass_high_phase", outs[PASS_IDX], !rst);
    @(negedge clk_in);
    check("pass_low_phase", outs[PASS_IDX], 1'b0);
    for (int i = 0; i < NUM; i++) begin
      if (i != PASS_IDX) begin
        check($sformatf("n%0d_out", NS[i]), outs[i], model_out(NS[i], k[i]));
        if (rst) begin
          last_rise[i] = -1;
        end else if (outs[i] && !prev[i]) begin
          if (last_rise[i] >= 0)
            check($sformatf("n%0d_period", NS[i]), cyc - last_rise[i], NS[i]);
          last_rise[i] = cyc;
        end
        prev[i] = outs[i];
      end
    end
  endtask

  initial begin
    int first_rise;
    int guard;
    for (int i = 0; i < NUM; i++) begin
      k[i]         = 0;
      last_rise[i] = -1;
      prev[i]      = 1'b0;
    end
    @(negedge clk_in);

    // Two reset cycles, then a long free run covering several periods of every ratio.
    step(1'b1);
    step(1'b1);
    for (int j = 0; j < 42; j++) step(1'b0);

    // Walk the N=10 divider to count 7 (high phase), then reset mid-period.
    guard = 0;
    while ((k[N10_IDX] % 10) != 7 && guard < 20) begin
      step(1'b0);
      guard++;
    end
    check("n10_reached_cnt7", guard < 20, 1'b1);
    check("n10_high_at_cnt7", outs[N10_IDX], 1'b1);
    step(1'b1);
    check("n10_low_after_reset", outs[N10_IDX], 1'b0);
    first_rise = 0;
    for (int j = 1; j <= 8; j++) begin
      step(1'b0);
      if (outs[N10_IDX] && first_rise == 0) first_rise = j;
    end
    check("n10_first_rise_edge", first_rise, 5);
    for (int j = 0; j < 25; j++) step(1'b0);

    // Random reset pulses over a long run; model and period tracking follow every edge.
    for (int j = 0; j < 600; j++) step($urandom_range(0, 19) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Parameterised integer clock divider: derives a slower square-wave clock `clk_out` from the single input clock `clk_in`.
- Used in the muon DAQ fabric wherever a lower-rate clock or strobe is needed from the 100 MHz system clock.
- Output is registered (glitch-free) for all division ratios ≥2.
- Ratio 1 is a defined pass-through.

Parameters:
- I_CLK_FREQ, 100_000_000, input clock frequency in Hz.
- O_CLK_FREQ, 1_000_000, requested output clock frequency in Hz.
- Derived constant N = I_CLK_FREQ / O_CLK_FREQ (integer division, truncating).
- Derived counter width W = max(1, $clog2(N)).

Ports:
- clk_in  input  1  input clock; all state updates on its rising edge.
- reset   input  1  synchronous, active-high reset.
- clk_out output 1  divided clock.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Elaboration checks (fatal error if violated):
  - O_CLK_FREQ > 0.
  - O_CLK_FREQ ≤ I_CLK_FREQ, so N ≥ 1.
- Non-integer ratio: N truncates; the actual output frequency is I_CLK_FREQ/N. No fractional division.
- N == 1 (pass-through mode): clk_out = clk_in & ~reset, combinational. No counter is instantiated.
- N ≥ 2, state:
  - counter cnt, W bits.
  - registered clk_out.
- N ≥ 2, reset: on a rising clk_in edge with reset=1, cnt←0 and clk_out←0. Reset dominates all other activity, including mid-period. The next period restarts from cnt=0.
- N ≥ 2, each non-reset rising edge:
  - cnt_next = (cnt == N-1) ? 0 : cnt+1.
  - cnt←cnt_next.
  - clk_out←(cnt_next ≥ ceil(N/2)).
- Resulting waveform (N ≥ 2):
  - Period is exactly N clk_in cycles.
  - Low for ceil(N/2) cycles, high for floor(N/2) cycles.
  - Odd N gives the extra cycle to the low phase.
  - N even gives 50 % duty.
- Latency: the first clk_out rising edge occurs on the ceil(N/2)-th rising clk_in edge after the first edge sampling reset=0.
- Wrap-around: cnt reaches N-1, then returns to 0. clk_out falls on that same edge. No skipped or extra cycles across periods.
- No unknown states:
  - cnt values ≥ N are unreachable.
  - If forced to such a value, the next edge loads 0.
- Before the first reset, clk_out and cnt are undefined in simulation. Implementation should initialise both to 0 where the target supports it.

Test Plan:
- I=100e6, O=25e6 (N=4): reset for 2 cycles, then release -> clk_out 0 during reset; pattern 0,0,1,1 repeating; period 4 cycles; first rise on 2nd edge after release.
- I=100e6, O=100e6 (N=1): toggle reset -> clk_out follows clk_in exactly when reset=0; clk_out held 0 while reset=1.
- I=100e6, O=33e6 (N=3): run 12 cycles -> low 2 cycles, high 1 cycle, exactly 4 periods; cycles-per-period counter always reads 3.
- I=100e6, O=50e6 (N=2): free run -> clk_out toggles every cycle (0,1,0,1...) starting low after reset.
- Reset mid-period, N=10: assert reset when cnt=7 (clk_out=1) -> clk_out 0 on the next edge; after release, the first rise occurs 5 edges later; period is 10 thereafter.
- Parameter check: O=200e6, I=100e6 -> elaboration fails with an error message.
